row_load_controller: RTL and testbench
======================================

Name: row_load_controller

Overview:
Byte-stream command sequencer between the controller UART receiver and the pixel framebuffer RAM. It parses row-load commands ('L', row index, 64 RGB565 pixels at 2 bytes each) arriving from the host link. It assembles the pixels and issues one framebuffer write per pixel with a {row, column} address. It also maintains a double-buffer select so the display scan reads a stable frame while the next one loads.

Parameters:
CMD_ROW, 8'h4C, command byte that starts a row load ('L')
CMD_SWAP, 8'h53, command byte that toggles the display/load buffer ('S')
ROW_BITS, 5, row index width (32 rows)
COL_BITS, 6, column index width
PIXELS_PER_ROW, 64, pixels per row load (must be at most 2**COL_BITS)
TIMEOUT_TICKS, 20'd160000, idle clocks mid-command before abort (10 ms at 16 MHz)
TIMEOUT_WIDTH, 5'd20, timeout counter width

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
ram_waddr  out  1+ROW_BITS+COL_BITS  {load_buffer, row, col}
ram_wdata  out  16  RGB565 pixel, first byte received = [15:8]
ram_we  out  1  one-cycle write strobe
display_buffer  out  1  buffer the scan logic reads; load_buffer = ~display_buffer
row_done  out  1  one-cycle pulse after the last pixel of a row is written
busy  out  1  high in any state other than IDLE
frame_error  out  1  sticky; set on timeout or on row index >= 2**ROW_BITS; cleared by the next CMD_ROW byte
rows_loaded  out  ROW_BITS+1  rows completed since the last swap; saturates at 2**ROW_BITS

Behaviour:
- Reset (async assert, sync release) sets every output to 0 and the FSM to IDLE.
- FSM advances only on cycles with rx_valid=1. Each FSM step below consumes one byte.
- IDLE:
  - CMD_ROW -> ROW; clear frame_error.
  - CMD_SWAP -> toggle display_buffer, clear rows_loaded, stay IDLE.
  - Any other byte is ignored, with no flag.
- ROW: latch row = rx_data[ROW_BITS-1:0]; col <= 0; -> PIX_HI.
  - If rx_data[7:ROW_BITS] != 0: set frame_error and enter DISCARD. DISCARD consumes 2*PIXELS_PER_ROW bytes without writing, then -> IDLE.
- PIX_HI: hold byte in hi_reg; -> PIX_LO.
- PIX_LO:
  - Next cycle: ram_we=1, ram_wdata={hi_reg, rx_data}, ram_waddr={~display_buffer, row, col}. Write latency is one clock after the low-byte strobe.
  - If col == PIXELS_PER_ROW-1: -> IDLE; row_done pulses in the same cycle as the final ram_we; rows_loaded increments, saturating.
  - Else col++ and -> PIX_HI.
- Command bytes inside a row are treated as pixel data (0x4C is a legal pixel byte). There is no resync mid-row except by timeout.
- Timeout:
  - Counter clears on every rx_valid and counts while busy.
  - At TIMEOUT_TICKS-1 with no byte: FSM -> IDLE, frame_error=1, partial row left in RAM, no row_done.
  - An rx_valid arriving in the same cycle as expiry wins: the byte is processed and the counter clears.
- A CMD_SWAP received while busy is pixel data and does not swap.
- Back-to-back rx_valid on consecutive cycles must be supported; ram_we can then assert every other cycle.
- Reset mid-row: immediate IDLE, no ram_we, buffer select returns to 0.

Test Plan:
- 'L',0x09, pixels 0x1234 then 62x 0x0000 then 0x5678 -> 64 ram_we; col0 addr {1,5'd9,6'd0} data 0x1234; col63 addr {1,5'd9,6'd63} data 0x5678; row_done coincident with the 64th write; rows_loaded=1.
- 'L',0x03 then 10 bytes, then silence for TIMEOUT_TICKS -> 5 writes, busy drops, frame_error=1, no row_done; next 'L' clears frame_error.
- 'L',0x25 (row>31) followed by 128 bytes -> frame_error=1, zero ram_we; FSM in IDLE afterwards; a following 'L',0x00 row writes normally.
- 'S' in IDLE -> display_buffer 0->1, rows_loaded=0; next row write uses address MSB 0. 'S' sent as a pixel byte -> no toggle.
- 'L',0x1F with rx_valid on every cycle -> writes exactly one clock after each low byte; no dropped pixels; 0x4C pixel bytes written as data.
- Assert reset after 'L',0x02 plus 20 bytes -> all outputs 0 asynchronously; after release, 'L',0x02 plus a full row -> 64 correct writes.

Source files
------------

// File: rtl/row_load_controller.sv
// Row-load command sequencer: parses 'L' row commands from the UART byte stream into
// per-pixel framebuffer writes and keeps the double-buffer select for the display scan.
module row_load_controller #(
    parameter logic [7:0]  CMD_ROW        = 8'h4C,
    parameter logic [7:0]  CMD_SWAP       = 8'h53,
    parameter int unsigned ROW_BITS       = 5,
    parameter int unsigned COL_BITS       = 6,
    parameter int unsigned PIXELS_PER_ROW = 64,
    parameter int unsigned TIMEOUT_TICKS  = 160000,
    parameter int unsigned TIMEOUT_WIDTH  = 20
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [ROW_BITS+COL_BITS:0]   ram_waddr,
    output logic [15:0]                  ram_wdata,
    output logic                         ram_we,
    output logic                         display_buffer,
    output logic                         row_done,
    output logic                         busy,
    output logic                         frame_error,
    output logic [ROW_BITS:0]            rows_loaded
);

    localparam int unsigned DISC_BYTES = 2 * PIXELS_PER_ROW;
    localparam int unsigned DISC_BITS  = $clog2(DISC_BYTES);

    localparam logic [COL_BITS-1:0]      LAST_COL  = COL_BITS'(PIXELS_PER_ROW - 1);
    localparam logic [DISC_BITS-1:0]     LAST_DISC = DISC_BITS'(DISC_BYTES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST_TICK = TIMEOUT_WIDTH'(TIMEOUT_TICKS - 1);
    localparam logic [ROW_BITS:0]        ROWS_MAX  = {1'b1, {ROW_BITS{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StRow,
        StPixHi,
        StPixLo,
        StDiscard
    } state_e;

    state_e                   state_q;
    logic [ROW_BITS-1:0]      row_q;
    logic [COL_BITS-1:0]      col_q;
    logic [7:0]               hi_q;
    logic [DISC_BITS-1:0]     disc_q;
    logic [TIMEOUT_WIDTH-1:0] tick_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            row_q          <= '0;
            col_q          <= '0;
            hi_q           <= '0;
            disc_q         <= '0;
            tick_q         <= '0;
            ram_waddr      <= '0;
            ram_wdata      <= '0;
            ram_we         <= 1'b0;
            display_buffer <= 1'b0;
            row_done       <= 1'b0;
            busy           <= 1'b0;
            frame_error    <= 1'b0;
            rows_loaded    <= '0;
        end else begin
            ram_we   <= 1'b0;
            row_done <= 1'b0;

            // A byte arriving on the expiry cycle takes priority over the timeout abort.
            if (rx_valid) begin
                tick_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        if (rx_data == CMD_ROW) begin
                            state_q     <= StRow;
                            busy        <= 1'b1;
                            frame_error <= 1'b0;
                        end else if (rx_data == CMD_SWAP) begin
                            display_buffer <= ~display_buffer;
                            rows_loaded    <= '0;
                        end
                    end
                    StRow: begin
                        row_q <= rx_data[ROW_BITS-1:0];
                        col_q <= '0;
                        if (rx_data[7:ROW_BITS] != '0) begin
                            frame_error <= 1'b1;
                            disc_q      <= '0;
                            state_q     <= StDiscard;
                        end else begin
                            state_q <= StPixHi;
                        end
                    end
                    StPixHi: begin
                        hi_q    <= rx_data;
                        state_q <= StPixLo;
                    end
                    StPixLo: begin
                        ram_we    <= 1'b1;
                        ram_wdata <= {hi_q, rx_data};
                        ram_waddr <= {~display_buffer, row_q, col_q};
                        if (col_q == LAST_COL) begin
                            state_q  <= StIdle;
                            busy     <= 1'b0;
                            row_done <= 1'b1;
                            if (rows_loaded != ROWS_MAX) begin
                                rows_loaded <= rows_loaded + 1'b1;
                            end
                        end else begin
                            col_q   <= col_q + 1'b1;
                            state_q <= StPixHi;
                        end
                    end
                    StDiscard: begin
                        if (disc_q == LAST_DISC) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            disc_q <= disc_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (state_q != StIdle) begin
                // Silent link mid-command: abandon the row, leaving any written pixels in RAM.
                if (tick_q == LAST_TICK) begin
                    state_q     <= StIdle;
                    busy        <= 1'b0;
                    frame_error <= 1'b1;
                    tick_q      <= '0;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end else begin
                tick_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_row_load_controller.sv
// Bench for row_load_controller: table of command vectors with fixed expectations, hand
// sequences for timeout/reset corners, and a randomized run against a write scoreboard.
module tb_row_load_controller;

    localparam int T = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        display_buffer;
    logic        row_done;
    logic        busy;
    logic        frame_error;
    logic [5:0]  rows_loaded;

    always #5 clk = ~clk;

    row_load_controller #(
        .TIMEOUT_TICKS(T)
    ) dut (
        .clk_in         (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .display_buffer (display_buffer),
        .row_done       (row_done),
        .busy           (busy),
        .frame_error    (frame_error),
        .rows_loaded    (rows_loaded)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes, recorded only by this monitor.
    logic [11:0] obs_addr [4096];
    logic [15:0] obs_data [4096];
    logic        obs_done [4096];
    int          obs_cyc  [4096];
    int          obs_n = 0;
    int          stray_done = 0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (obs_n < 4096) begin
                obs_addr[obs_n] <= ram_waddr;
                obs_data[obs_n] <= ram_wdata;
                obs_done[obs_n] <= row_done;
                obs_cyc[obs_n]  <= cyc;
            end
            obs_n <= obs_n + 1;
        end
        if (row_done === 1'b1 && ram_we !== 1'b1) stray_done <= stray_done + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame-level state plus the list of writes the byte stream implies.
    logic        m_disp = 1'b0;
    int          m_rows = 0;
    logic        m_ferr = 1'b0;
    logic [11:0] e_addr [$];
    logic [15:0] e_data [$];
    logic        e_done [$];
    int          e_cyc  [$];
    int          rd = 0;
    logic [15:0] pix [64];

    task automatic send_byte(input logic [7:0] b, input int gap, output int dc);
        rx_data  = b;
        rx_valid = 1'b1;
        dc       = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push_exp(input logic [4:0] row, input int col, input logic [15:0] d,
                            input logic done, input int wc);
        e_addr.push_back({~m_disp, row, 6'(col)});
        e_data.push_back(d);
        e_done.push_back(done);
        e_cyc.push_back(wc);
    endtask

    // 'L', row byte, then nbytes of pixel stream taken from pix[] (high byte first).
    task automatic do_row(input logic [7:0] rb, input int nbytes, input int gapmax);
        int   dc;
        int   g;
        logic bad;
        logic [7:0] b;
        bad = (rb > 8'd31);
        send_byte(8'h4C, $urandom_range(gapmax, 0), dc);
        m_ferr = 1'b0;
        send_byte(rb, (nbytes == 0) ? 0 : $urandom_range(gapmax, 0), dc);
        if (bad) m_ferr = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            b = (i % 2 == 0) ? pix[i / 2][15:8] : pix[i / 2][7:0];
            g = (i == nbytes - 1) ? 0 : $urandom_range(gapmax, 0);
            send_byte(b, g, dc);
            if (!bad && (i % 2 == 1)) begin
                push_exp(rb[4:0], i / 2, pix[i / 2], (i / 2 == 63), dc + 1);
                if (i / 2 == 63 && m_rows < 32) m_rows++;
            end
        end
    endtask

    task automatic check_writes(input string name);
        repeat (2) @(negedge clk);
        chk({name, " write count"}, 32'(obs_n), 32'(e_addr.size()));
        for (int i = rd; i < e_addr.size(); i++) begin
            if (i < obs_n) begin
                chk({name, " addr/data/done"}, {3'b0, obs_addr[i], obs_data[i], obs_done[i]},
                    {3'b0, e_addr[i], e_data[i], e_done[i]});
                chk({name, " write cycle"}, 32'(obs_cyc[i]), 32'(e_cyc[i]));
            end
        end
        rd = e_addr.size();
    endtask

    task automatic check_status(input string name);
        chk({name, " busy"}, 32'(busy), 32'(0));
        chk({name, " display_buffer"}, 32'(display_buffer), 32'(m_disp));
        chk({name, " rows_loaded"}, 32'(rows_loaded), 32'(m_rows));
        chk({name, " frame_error"}, 32'(frame_error), 32'(m_ferr));
    endtask

    task automatic rand_pix();
        for (int i = 0; i < 64; i++) pix[i] = 16'($urandom);
    endtask

    typedef struct {
        int         kind;      // 0 row, 1 swap, 2 bad row + 128 bytes, 3 back-to-back row
        logic [7:0] row;
        logic       exp_disp;
        int         exp_rows;
        logic       exp_ferr;
        int         exp_writes;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int dc;
        int base;
        int k;

        tbl[0] = '{0, 8'h09, 1'b0, 1, 1'b0, 64};
        tbl[1] = '{3, 8'h1F, 1'b0, 2, 1'b0, 64};
        tbl[2] = '{2, 8'h25, 1'b0, 2, 1'b1, 0};
        tbl[3] = '{0, 8'h00, 1'b0, 3, 1'b0, 64};
        tbl[4] = '{1, 8'h00, 1'b1, 0, 1'b0, 0};
        tbl[5] = '{0, 8'h05, 1'b1, 1, 1'b0, 64};
        tbl[6] = '{1, 8'h00, 1'b0, 0, 1'b0, 0};
        tbl[7] = '{2, 8'hE0, 1'b0, 0, 1'b1, 0};
        tbl[8] = '{1, 8'h00, 1'b1, 0, 1'b1, 0};

        #3 reset = 1'b0;
        #2;
        chk("reset ram_we", 32'(ram_we), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset outputs", {ram_waddr, ram_wdata, display_buffer, row_done, frame_error},
            32'(0));
        chk("reset rows_loaded", 32'(rows_loaded), 32'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            base = obs_n;
            rand_pix();
            if (v == 0) begin
                for (int i = 0; i < 64; i++) pix[i] = 16'h0000;
                pix[0]  = 16'h1234;
                pix[63] = 16'h5678;
            end
            if (tbl[v].kind == 3) begin
                pix[5]  = 16'h4C4C;
                pix[20] = 16'h534C;
                pix[63] = 16'h4C53;
            end
            case (tbl[v].kind)
                0: do_row(tbl[v].row, 128, 2);
                1: begin
                    send_byte(8'h53, 1, dc);
                    m_disp = ~m_disp;
                    m_rows = 0;
                end
                2: do_row(tbl[v].row, 128, 1);
                default: do_row(tbl[v].row, 128, 0);
            endcase
            check_writes($sformatf("vec%0d", v));
            chk($sformatf("vec%0d busy", v), 32'(busy), 32'(0));
            chk($sformatf("vec%0d display_buffer", v), 32'(display_buffer), 32'(tbl[v].exp_disp));
            chk($sformatf("vec%0d rows_loaded", v), 32'(rows_loaded), 32'(tbl[v].exp_rows));
            chk($sformatf("vec%0d frame_error", v), 32'(frame_error), 32'(tbl[v].exp_ferr));
            chk($sformatf("vec%0d writes", v), 32'(obs_n - base), 32'(tbl[v].exp_writes));
            if (v == 0) begin
                chk("row9 col0 addr", 32'(obs_addr[base]), 32'(12'hA40));
                chk("row9 col0 data", 32'(obs_data[base]), 32'(16'h1234));
                chk("row9 col63 addr", 32'(obs_addr[base + 63]), 32'(12'hA7F));
                chk("row9 col63 data", 32'(obs_data[base + 63]), 32'(16'h5678));
                chk("row9 row_done", 32'(obs_done[base + 63]), 32'(1));
            end
            if (v == 5) chk("after swap addr msb", 32'(obs_addr[base][11]), 32'(0));
        end

        // Timeout mid-row: 5 pixels land, abort exactly TIMEOUT_TICKS clocks after last byte.
        rand_pix();
        do_row(8'h03, 10, 0);
        repeat (T - 1) @(negedge clk);
        chk("timeout pre-expiry busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("timeout busy", 32'(busy), 32'(0));
        chk("timeout frame_error", 32'(frame_error), 32'(1));
        m_ferr = 1'b1;
        check_writes("timeout");
        check_status("timeout");
        send_byte(8'h4C, 0, dc);
        chk("L clears frame_error", 32'(frame_error), 32'(0));
        chk("L sets busy", 32'(busy), 32'(1));
        repeat (T + 2) @(negedge clk);
        m_ferr = 1'b1;
        check_status("timeout after L");

        // Byte on the expiry cycle wins over the abort.
        rand_pix();
        do_row(8'h04, 1, 0);
        repeat (T - 1) @(negedge clk);
        send_byte(pix[0][7:0], 0, dc);
        push_exp(5'd4, 0, pix[0], 1'b0, dc + 1);
        chk("expiry race busy", 32'(busy), 32'(1));
        repeat (T + 2) @(negedge clk);
        m_ferr = 1'b1;
        check_writes("expiry race");
        check_status("expiry race");

        // Reset mid-row with display_buffer currently 1.
        rand_pix();
        do_row(8'h02, 20, 0);
        reset = 1'b0;
        #1;
        chk("midrow reset we/done/busy", {ram_we, row_done, busy}, 32'(0));
        chk("midrow reset buffer/ferr", {display_buffer, frame_error}, 32'(0));
        chk("midrow reset rows_loaded", 32'(rows_loaded), 32'(0));
        chk("midrow reset addr/data", {ram_waddr, ram_wdata}, 32'(0));
        m_disp = 1'b0;
        m_rows = 0;
        m_ferr = 1'b0;
        check_writes("midrow reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rand_pix();
        do_row(8'h02, 128, 1);
        check_writes("after reset row");
        check_status("after reset row");

        // Randomized command mix.
        for (int n = 0; n < 15; n++) begin
            rand_pix();
            k = $urandom_range(9, 0);
            if (k <= 5) begin
                do_row(8'($urandom_range(31, 0)), 128, $urandom_range(3, 0));
            end else if (k <= 7) begin
                send_byte(8'h53, $urandom_range(3, 0), dc);
                m_disp = ~m_disp;
                m_rows = 0;
            end else if (k == 8) begin
                do_row(8'($urandom_range(255, 32)), 128, $urandom_range(2, 0));
            end else begin
                do_row(8'($urandom_range(31, 0)), $urandom_range(127, 1), 2);
                repeat (T + 1) @(negedge clk);
                m_ferr = 1'b1;
            end
            check_writes($sformatf("rand%0d", n));
            check_status($sformatf("rand%0d", n));
        end

        chk("row_done without write", 32'(stray_done), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
